// File: rtl/cordic_rr_scheduler_pkg.sv
// Shared definitions for the Cordic round-robin scheduler.
//   sched_state_e : scheduler FSM states
//   clog2_min1    : ceil(log2(value)), never less than 1, for sizing tags/counters
package cordic_rr_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_DRAINING = 2'd2,
    ST_DRAINED  = 2'd3
  } sched_state_e;

  function automatic int clog2_min1(input int value);
    int width;
    width = 1;
    for (int i = 1; i < 31; i++) begin
      width = ((32'sd1 << i) < value) ? (i + 1) : width;
    end
    return width;
  endfunction

endpackage

// File: rtl/cordic_rr_scheduler_if.sv
// Requester-side bus of the Cordic scheduler.
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_x/req_y/req_phase : packed operands, requester i at slice i
//   rsp_valid : one-hot result strobe, no backpressure
//   rsp_x/rsp_y/rsp_phase : shared result bus
// master = requester side, slave = scheduler side.
interface cordic_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int XY_BITS = 12,
  parameter int PH_BITS = 32
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*XY_BITS-1:0] req_x;
  logic [NUM_REQ*XY_BITS-1:0] req_y;
  logic [NUM_REQ*PH_BITS-1:0] req_phase;
  logic [NUM_REQ-1:0]         rsp_valid;
  logic [XY_BITS-1:0]         rsp_x;
  logic [XY_BITS-1:0]         rsp_y;
  logic [PH_BITS-1:0]         rsp_phase;

  modport master (
    output req_valid, req_x, req_y, req_phase,
    input  req_ready, rsp_valid, rsp_x, rsp_y, rsp_phase
  );

  modport slave (
    input  req_valid, req_x, req_y, req_phase,
    output req_ready, rsp_valid, rsp_x, rsp_y, rsp_phase
  );
endinterface

// File: rtl/cordic_rr_scheduler_tag_fifo.sv
// Synchronous FIFO holding the requester tag of every op inside the Cordic.
//   clk_in, RST     : clock, synchronous active-high reset
//   push/push_data  : write one tag (ignored when full)
//   pop/pop_data    : read the oldest tag (ignored when empty); pop_data is
//                     the head entry, valid whenever empty is low
//   full/empty      : status
//   count           : number of stored tags
module cordic_tag_fifo
  import cordic_rr_scheduler_pkg::*;
#(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 40,
  localparam int PTR_W = clog2_min1(DEPTH),
  localparam int CNT_W = clog2_min1(DEPTH + 1)
) (
  input  logic             clk_in,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == CNT_W'(0));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap at DEPTH, which need not be a power of two
  always_comb begin
    push_ok_s = push & ~full;
    pop_ok_s  = pop & ~empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push_ok_s) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : (wr_ptr_q + PTR_W'(1));
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : (rd_ptr_q + PTR_W'(1));
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers
  always_ff @(posedge clk_in) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage; entries are only read after being written, so no reset needed
  always_ff @(posedge clk_in) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/cordic_rr_scheduler.sv
// Shares one pipelined Cordic among NUM_REQ requesters.
//   clk_in, RST            : clock, synchronous active-high reset (shared with Cordic)
//   req_if (slave)         : requester handshake, operands and routed results
//   cor_x_i/cor_y_i/cor_phase_in/cor_valid_in : registered op towards the Cordic
//   cor_x_o/cor_y_o/cor_phase_out/cor_valid_out : Cordic result
//   drain_req/drain_done   : stop issuing and report once the pipe is empty
//   inflight               : ops issued but not yet returned
//   err_orphan             : sticky, a Cordic result arrived with no tag waiting
// Round-robin grant, one op per cycle; each op's requester tag is queued and
// used to steer the result back when the Cordic returns it (in order).
module cordic_rr_scheduler
  import cordic_rr_scheduler_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int XY_BITS      = 12,
  parameter  int PH_BITS      = 32,
  parameter  int MAX_INFLIGHT = 40,
  localparam int TAG_W        = clog2_min1(NUM_REQ),
  localparam int CNT_W        = clog2_min1(MAX_INFLIGHT + 1)
) (
  input  logic                  clk_in,
  input  logic                  RST,
  cordic_rr_scheduler_if.slave  req_if,
  output logic [XY_BITS-1:0]    cor_x_i,
  output logic [XY_BITS-1:0]    cor_y_i,
  output logic [PH_BITS-1:0]    cor_phase_in,
  output logic                  cor_valid_in,
  input  logic [XY_BITS-1:0]    cor_x_o,
  input  logic [XY_BITS-1:0]    cor_y_o,
  input  logic [PH_BITS-1:0]    cor_phase_out,
  input  logic                  cor_valid_out,
  input  logic                  drain_req,
  output logic                  drain_done,
  output logic [CNT_W-1:0]      inflight,
  output logic                  err_orphan
);

  sched_state_e       state_q, state_d;
  logic [TAG_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [XY_BITS-1:0] cor_x_q, cor_x_d, cor_y_q, cor_y_d;
  logic [PH_BITS-1:0] cor_ph_q, cor_ph_d;
  logic               cor_valid_q, cor_valid_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [XY_BITS-1:0] rsp_x_q, rsp_x_d, rsp_y_q, rsp_y_d;
  logic [PH_BITS-1:0] rsp_ph_q, rsp_ph_d;
  logic               err_orphan_q, err_orphan_d;
  logic               drain_done_q, drain_done_d;

  logic [TAG_W-1:0]   cand_s;
  logic [TAG_W-1:0]   grant_idx_s;
  logic               grant_any_s;
  logic [NUM_REQ-1:0] grant_oh_s;
  logic               can_issue_s;
  logic               accept_s;
  logic               pop_s;
  logic               orphan_s;
  logic [TAG_W-1:0]   pop_tag_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [CNT_W-1:0]   fifo_count_s;
  logic [CNT_W-1:0]   inflight_next_s;

  function automatic logic [TAG_W-1:0] wrap_add(input logic [TAG_W-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    sum = (sum >= NUM_REQ) ? (sum - NUM_REQ) : sum;
    return TAG_W'(sum);
  endfunction

  cordic_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk_in    (clk_in),
    .RST       (RST),
    .push      (accept_s),
    .push_data (grant_idx_s),
    .pop       (pop_s),
    .pop_data  (pop_tag_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  assign req_if.req_ready = grant_oh_s & {NUM_REQ{can_issue_s}};
  assign accept_s         = grant_any_s & can_issue_s;
  assign pop_s            = cor_valid_out & ~fifo_empty_s;
  assign orphan_s         = cor_valid_out & fifo_empty_s;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s      = wrap_add(rr_ptr_q, k);
      grant_idx_s = (!grant_any_s && req_if.req_valid[cand_s]) ? cand_s : grant_idx_s;
      grant_any_s = grant_any_s | req_if.req_valid[cand_s];
    end
    grant_oh_s = grant_any_s ? (NUM_REQ'(1) << grant_idx_s) : NUM_REQ'(0);
  end

  // Issue path, return path and orphan flag next-state
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    cor_x_d      = cor_x_q;
    cor_y_d      = cor_y_q;
    cor_ph_d     = cor_ph_q;
    cor_valid_d  = accept_s;
    rsp_valid_d  = NUM_REQ'(0);
    rsp_x_d      = rsp_x_q;
    rsp_y_d      = rsp_y_q;
    rsp_ph_d     = rsp_ph_q;
    err_orphan_d = err_orphan_q | orphan_s;
    if (accept_s) begin
      rr_ptr_d = wrap_add(grant_idx_s, 1);
      cor_x_d  = req_if.req_x[int'(grant_idx_s)*XY_BITS +: XY_BITS];
      cor_y_d  = req_if.req_y[int'(grant_idx_s)*XY_BITS +: XY_BITS];
      cor_ph_d = req_if.req_phase[int'(grant_idx_s)*PH_BITS +: PH_BITS];
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    if (pop_s) begin
      rsp_valid_d = NUM_REQ'(1) << pop_tag_s;
      rsp_x_d     = cor_x_o;
      rsp_y_d     = cor_y_o;
      rsp_ph_d    = cor_phase_out;
    end else begin
      rsp_valid_d = NUM_REQ'(0);
    end
    case ({accept_s, pop_s})
      2'b10:   inflight_next_s = fifo_count_s + CNT_W'(1);
      2'b01:   inflight_next_s = fifo_count_s - CNT_W'(1);
      default: inflight_next_s = fifo_count_s;
    endcase
  end

  // FSM next state; drain has priority in every state
  always_comb begin
    state_d = state_q;
    if (drain_req) begin
      case (state_q)
        ST_DRAINED:  state_d = ST_DRAINED;
        ST_DRAINING: state_d = (fifo_count_s == CNT_W'(0)) ? ST_DRAINED : ST_DRAINING;
        // An op accepted this cycle still has to come back before DRAINED
        default:     state_d = ((fifo_count_s == CNT_W'(0)) && !accept_s) ? ST_DRAINED : ST_DRAINING;
      endcase
    end else begin
      case (state_q)
        ST_IDLE:     state_d = accept_s ? ST_RUN : ST_IDLE;
        ST_RUN:      state_d = (inflight_next_s == CNT_W'(0)) ? ST_IDLE : ST_RUN;
        // Drain withdrawn before completion: resume normal operation
        ST_DRAINING: state_d = (fifo_count_s == CNT_W'(0)) ? ST_IDLE : ST_RUN;
        ST_DRAINED:  state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: issue permission and drain status
  always_comb begin
    can_issue_s  = (state_q != ST_DRAINING) && (state_q != ST_DRAINED) && !fifo_full_s;
    drain_done_d = (state_d == ST_DRAINED);
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and status registers
  always_ff @(posedge clk_in) begin
    if (RST) begin
      rr_ptr_q     <= '0;
      cor_x_q      <= '0;
      cor_y_q      <= '0;
      cor_ph_q     <= '0;
      cor_valid_q  <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_x_q      <= '0;
      rsp_y_q      <= '0;
      rsp_ph_q     <= '0;
      err_orphan_q <= 1'b0;
      drain_done_q <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      cor_x_q      <= cor_x_d;
      cor_y_q      <= cor_y_d;
      cor_ph_q     <= cor_ph_d;
      cor_valid_q  <= cor_valid_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_x_q      <= rsp_x_d;
      rsp_y_q      <= rsp_y_d;
      rsp_ph_q     <= rsp_ph_d;
      err_orphan_q <= err_orphan_d;
      drain_done_q <= drain_done_d;
    end
  end

  assign cor_x_i          = cor_x_q;
  assign cor_y_i          = cor_y_q;
  assign cor_phase_in     = cor_ph_q;
  assign cor_valid_in     = cor_valid_q;
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_x     = rsp_x_q;
  assign req_if.rsp_y     = rsp_y_q;
  assign req_if.rsp_phase = rsp_ph_q;
  assign drain_done       = drain_done_q;
  assign inflight         = fifo_count_s;
  assign err_orphan       = err_orphan_q;

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Bench for cordic_rr_scheduler: 4 requesters, MAX_INFLIGHT=4, a queue-based
// Cordic stand-in with latency 2 that can be stalled, and a scoreboard of
// expected results pushed at accept time and popped on rsp_valid.
module tb_cordic_rr_scheduler;

  localparam int NR   = 4;
  localparam int XB   = 12;
  localparam int PB   = 32;
  localparam int MAXI = 4;
  localparam int CW   = 3;
  localparam int LAT  = 2;

  logic          clk_in = 1'b0;
  logic          RST;
  logic [XB-1:0] cor_x_i, cor_y_i, cor_x_o, cor_y_o;
  logic [PB-1:0] cor_phase_in, cor_phase_out;
  logic          cor_valid_in, cor_valid_out;
  logic          drain_req, drain_done, err_orphan;
  logic [CW-1:0] inflight;

  cordic_rr_scheduler_if #(.NUM_REQ(NR), .XY_BITS(XB), .PH_BITS(PB)) rif ();

  cordic_rr_scheduler #(.NUM_REQ(NR), .XY_BITS(XB), .PH_BITS(PB), .MAX_INFLIGHT(MAXI)) dut (
    .clk_in(clk_in), .RST(RST), .req_if(rif),
    .cor_x_i(cor_x_i), .cor_y_i(cor_y_i), .cor_phase_in(cor_phase_in), .cor_valid_in(cor_valid_in),
    .cor_x_o(cor_x_o), .cor_y_o(cor_y_o), .cor_phase_out(cor_phase_out), .cor_valid_out(cor_valid_out),
    .drain_req(drain_req), .drain_done(drain_done), .inflight(inflight), .err_orphan(err_orphan)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct { logic [1:0] tag; logic [XB-1:0] x; logic [XB-1:0] y; logic [PB-1:0] ph; int acc_cyc; } exp_t;
  typedef struct { int due; logic [XB-1:0] x; logic [XB-1:0] y; logic [PB-1:0] ph; } cop_t;
  exp_t sb_q[$];
  cop_t cm_q[$];

  int n_checks = 0, n_fail = 0;
  int pending[NR];
  logic [XB-1:0] cx[NR], cy[NR];
  logic [PB-1:0] cph[NR];
  bit  acc_flag[NR];
  int  acc_cnt[NR];
  bit  stall = 1'b0, force_orphan = 1'b0, lat_chk = 1'b1;
  int  rsp_cnt = 0, last_rsp_cyc = 0, first_acc_cyc = -1, last_acc_cyc = 0;
  int  exp_ptr = 0;
  bit  prev_acc = 1'b0;
  logic [XB-1:0] prev_x, prev_y;
  logic [PB-1:0] prev_ph;

  // Stand-in Cordic transfer function
  function automatic logic [XB-1:0] fx(input logic [XB-1:0] x);
    return x ^ 12'hA5A;
  endfunction
  function automatic logic [XB-1:0] fy(input logic [XB-1:0] x, input logic [XB-1:0] y);
    return y + x;
  endfunction
  function automatic logic [PB-1:0] fph(input logic [PB-1:0] ph);
    return ph + 32'h0000_0001;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic load_req(input int i, input int n, input logic [XB-1:0] x, input logic [XB-1:0] y,
                          input logic [PB-1:0] ph);
    cx[i] = x; cy[i] = y; cph[i] = ph; pending[i] = n;
  endtask

  task automatic step();
    @(posedge clk_in); #2;
  endtask

  task automatic wait_quiet(input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk_in); #1;
      done = (pending[0] == 0) && (pending[1] == 0) && (pending[2] == 0) && (pending[3] == 0) &&
             (sb_q.size() == 0) && (inflight == CW'(0));
    end
    check_val("quiet_timeout", 64'(done), 64'd1);
  endtask

  // Requester and Cordic stand-in drivers, 1 ns after each rising edge
  initial begin
    forever begin
      @(posedge clk_in); #1;
      for (int i = 0; i < NR; i++) begin
        if (acc_flag[i]) begin
          acc_flag[i] = 1'b0;
          pending[i]  = pending[i] - 1;
          if (pending[i] > 0) begin
            cx[i] = 12'($urandom); cy[i] = 12'($urandom); cph[i] = $urandom;
          end
        end
        rif.req_valid[i]            = (pending[i] > 0);
        rif.req_x[i*XB +: XB]       = cx[i];
        rif.req_y[i*XB +: XB]       = cy[i];
        rif.req_phase[i*PB +: PB]   = cph[i];
      end
      if (RST) begin
        cor_valid_out = 1'b0;
      end else if (force_orphan) begin
        cor_valid_out = 1'b1; cor_x_o = 12'h7FF; cor_y_o = 12'h123; cor_phase_out = 32'hDEAD_BEEF;
      end else if (!stall && cm_q.size() > 0 && cm_q[0].due <= cyc) begin
        cop_t c;
        c = cm_q.pop_front();
        cor_valid_out = 1'b1; cor_x_o = fx(c.x); cor_y_o = fy(c.x, c.y); cor_phase_out = fph(c.ph);
      end else begin
        cor_valid_out = 1'b0;
      end
    end
  end

  // Monitor: issue checks, grant model, scoreboard, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk_in);
      if (RST) begin
        sb_q.delete(); cm_q.delete(); prev_acc = 1'b0; exp_ptr = 0;
      end else begin
        logic [NR-1:0] acc;
        int idx;
        check_val("cor_valid_in", 64'(cor_valid_in), 64'(prev_acc));
        if (prev_acc) begin
          check_val("cor_x_i", 64'(cor_x_i), 64'(prev_x));
          check_val("cor_y_i", 64'(cor_y_i), 64'(prev_y));
          check_val("cor_phase_in", 64'(cor_phase_in), 64'(prev_ph));
        end
        if (cor_valid_in) cm_q.push_back('{cyc + LAT, cor_x_i, cor_y_i, cor_phase_in});
        check_val("ready_onehot", 64'($countones(rif.req_ready) <= 1), 64'd1);
        acc = rif.req_valid & rif.req_ready;
        prev_acc = 1'b0;
        if (acc != '0) begin
          idx = -1;
          for (int k = 0; k < NR; k++) begin
            if (idx < 0 && rif.req_valid[(exp_ptr + k) % NR]) idx = (exp_ptr + k) % NR;
          end
          check_val("grant_idx", 64'(acc), 64'(1) << idx);
          exp_ptr = (idx + 1) % NR;
          sb_q.push_back('{2'(idx), fx(cx[idx]), fy(cx[idx], cy[idx]), fph(cph[idx]), cyc});
          prev_x = cx[idx]; prev_y = cy[idx]; prev_ph = cph[idx];
          prev_acc = 1'b1;
          acc_cnt[idx]++;
          acc_flag[idx] = 1'b1;
          if (first_acc_cyc < 0) first_acc_cyc = cyc;
          last_acc_cyc = cyc;
        end
        if (rif.rsp_valid != '0) begin
          if (sb_q.size() == 0) begin
            check_val("rsp_unexpected", 64'(rif.rsp_valid), 64'd0);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            check_val("rsp_valid", 64'(rif.rsp_valid), 64'(1) << e.tag);
            check_val("rsp_x", 64'(rif.rsp_x), 64'(e.x));
            check_val("rsp_y", 64'(rif.rsp_y), 64'(e.y));
            check_val("rsp_phase", 64'(rif.rsp_phase), 64'(e.ph));
            if (lat_chk) check_val("latency", 64'(cyc - e.acc_cyc), 64'(LAT + 2));
          end
          rsp_cnt++;
          last_rsp_cyc = cyc;
        end
        check_val("inflight_max", 64'(inflight <= CW'(MAXI)), 64'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dd_cyc, rsp_base;
    RST = 1'b1; drain_req = 1'b0;
    for (int i = 0; i < NR; i++) begin pending[i] = 0; acc_flag[i] = 1'b0; acc_cnt[i] = 0; end
    cor_valid_out = 1'b0; cor_x_o = '0; cor_y_o = '0; cor_phase_out = '0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_val("rst_rsp_valid", 64'(rif.rsp_valid), 64'd0);
    check_val("rst_req_ready", 64'(rif.req_ready), 64'd0);
    check_val("rst_cor_valid_in", 64'(cor_valid_in), 64'd0);
    check_val("rst_cor_x_i", 64'(cor_x_i), 64'd0);
    check_val("rst_inflight", 64'(inflight), 64'd0);
    check_val("rst_drain_done", 64'(drain_done), 64'd0);
    check_val("rst_err_orphan", 64'(err_orphan), 64'd0);
    step(); RST = 1'b0;

    // T1: single op from requester 0
    step();
    load_req(0, 1, 12'd100, 12'd0, 32'h2000_0000);
    wait_quiet(40);
    check_val("t1_accepts", 64'(acc_cnt[0]), 64'd1);
    check_val("t1_rsp_cnt", 64'(rsp_cnt), 64'd1);

    // T2: all four requesters busy, 4 ops each, back-to-back
    step();
    for (int i = 0; i < NR; i++) begin
      acc_cnt[i] = 0;
      load_req(i, 4, 12'($urandom), 12'($urandom), $urandom);
    end
    first_acc_cyc = -1;
    wait_quiet(80);
    for (int i = 0; i < NR; i++) check_val("t2_fair_count", 64'(acc_cnt[i]), 64'd4);
    check_val("t2_back_to_back", 64'(last_acc_cyc - first_acc_cyc), 64'd15);

    // T3: stalled Cordic, in-flight limit
    lat_chk = 1'b0;
    step();
    acc_cnt[0] = 0; stall = 1'b1;
    load_req(0, 6, 12'h011, 12'h022, 32'h1234_5678);
    repeat (10) step();
    @(negedge clk_in); #1;
    check_val("t3_accepts_at_limit", 64'(acc_cnt[0]), 64'd4);
    check_val("t3_inflight_full", 64'(inflight), 64'd4);
    check_val("t3_ready_blocked", 64'(rif.req_ready), 64'd0);
    check_val("t3_still_valid", 64'(rif.req_valid[0]), 64'd1);
    step(); stall = 1'b0;
    wait_quiet(60);
    check_val("t3_all_accepted", 64'(acc_cnt[0]), 64'd6);

    // T4: push and pop in the same cycle at inflight=3
    step();
    stall = 1'b1;
    load_req(1, 3, 12'h101, 12'h102, 32'h0000_0103);
    repeat (6) step();
    @(negedge clk_in);
    check_val("t4_inflight_pre", 64'(inflight), 64'd3);
    step();
    stall = 1'b0;
    load_req(2, 1, 12'h201, 12'h202, 32'h0000_0203);
    @(negedge clk_in);
    @(negedge clk_in);
    check_val("t4_push_and_pop", 64'(rif.req_ready[2] & cor_valid_out), 64'd1);
    @(negedge clk_in);
    check_val("t4_inflight_same", 64'(inflight), 64'd3);
    wait_quiet(40);

    // Drain request while idle reaches DRAINED on the next cycle
    step();
    drain_req = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    check_val("drain_idle_fast", 64'(drain_done), 64'd1);
    step();
    drain_req = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    check_val("drain_release", 64'(drain_done), 64'd0);

    // T5: drain with the pipe full
    step();
    stall = 1'b1; acc_cnt[0] = 0;
    load_req(3, 4, 12'h301, 12'h302, 32'h0000_0303);
    repeat (8) step();
    @(negedge clk_in);
    check_val("t5_inflight", 64'(inflight), 64'd4);
    step(); drain_req = 1'b1;
    step();
    load_req(0, 2, 12'h0A1, 12'h0A2, 32'h0000_00A3);
    repeat (4) step();
    @(negedge clk_in);
    check_val("t5_no_grant", 64'(rif.req_ready), 64'd0);
    check_val("t5_not_done", 64'(drain_done), 64'd0);
    step();
    rsp_base = rsp_cnt; dd_cyc = -1; stall = 1'b0;
    for (int c = 0; c < 30 && dd_cyc < 0; c++) begin
      @(negedge clk_in); #1;
      if (drain_done) dd_cyc = cyc;
    end
    check_val("t5_drained_results", 64'(rsp_cnt - rsp_base), 64'd4);
    check_val("t5_done_timing", 64'(dd_cyc - last_rsp_cyc), 64'd1);
    check_val("t5_no_accept", 64'(acc_cnt[0]), 64'd0);
    step(); drain_req = 1'b0;
    wait_quiet(40);
    check_val("t5_resume", 64'(acc_cnt[0]), 64'd2);
    check_val("t5_idle_done_low", 64'(drain_done), 64'd0);

    // T6: orphan result, then reset in the middle of a burst
    step(); force_orphan = 1'b1;
    step(); force_orphan = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    check_val("t6_err_orphan", 64'(err_orphan), 64'd1);
    check_val("t6_orphan_no_rsp", 64'(rif.rsp_valid), 64'd0);
    check_val("t6_orphan_inflight", 64'(inflight), 64'd0);
    step();
    for (int i = 0; i < NR; i++) load_req(i, 5, 12'($urandom), 12'($urandom), $urandom);
    repeat (6) step();
    RST = 1'b1;
    for (int i = 0; i < NR; i++) begin pending[i] = 0; acc_flag[i] = 1'b0; end
    @(posedge clk_in);
    @(negedge clk_in);
    check_val("t6_rst_rsp_valid", 64'(rif.rsp_valid), 64'd0);
    check_val("t6_rst_req_ready", 64'(rif.req_ready), 64'd0);
    check_val("t6_rst_cor_valid_in", 64'(cor_valid_in), 64'd0);
    check_val("t6_rst_cor_x_i", 64'(cor_x_i), 64'd0);
    check_val("t6_rst_rsp_x", 64'(rif.rsp_x), 64'd0);
    check_val("t6_rst_inflight", 64'(inflight), 64'd0);
    check_val("t6_rst_err_orphan", 64'(err_orphan), 64'd0);
    check_val("t6_rst_drain_done", 64'(drain_done), 64'd0);
    step(); RST = 1'b0;
    repeat (10) step();
    lat_chk = 1'b1; acc_cnt[2] = 0;
    load_req(2, 1, 12'h0F0, 12'h00F, 32'h4000_0000);
    wait_quiet(40);
    check_val("t6_recover", 64'(acc_cnt[2]), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
